// File: rtl/pipeline_types.sv
// Shared pipeline payload types for the dispatch stage and its neighbours.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package pipeline_types;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 4;

  // Decoded op arriving from the decode stage.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [ALUOP_W-1:0] aluop;
    logic               reg1_en;
    logic [REG_AW-1:0]  reg1_addr;
    logic               reg2_en;
    logic [REG_AW-1:0]  reg2_addr;
    logic               dest_en;
    logic [REG_AW-1:0]  dest_addr;
    logic               is_load;
    logic [XLEN-1:0]    imm;
  } dispatch_in_t;

  // Op with both source operands resolved, handed to execute.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [ALUOP_W-1:0] aluop;
    logic               dest_en;
    logic [REG_AW-1:0]  dest_addr;
    logic               is_load;
    logic [XLEN-1:0]    operand1;
    logic [XLEN-1:0]    operand2;
  } dispatch_out_t;

  // Forwarding bus from a later stage. is_load only matters on the EX bus.
  typedef struct packed {
    logic               valid;
    logic               is_load;
    logic [REG_AW-1:0]  addr;
    logic [XLEN-1:0]    data;
  } fwd_t;

  // True when a forwarding bus carries a result for the given register.
  function automatic logic fwd_hit(input fwd_t f, input logic [REG_AW-1:0] a);
    return f.valid && (f.addr == a);
  endfunction

endpackage

// File: rtl/operand_mux.sv
// Resolves one source operand: r0, EX forward, MEM forward, regfile, or disabled value.
// Latency: combinational, 0 cycles.
// Backpressure: none; flags a hazard when the operand cannot be resolved yet.
// DISPATCH_MEM_FWD_EN defined: MEM results are forwarded; undefined: a MEM hit stalls.
module operand_mux
  import pipeline_types::*;
(
  input  logic              en_i,
  input  logic [REG_AW-1:0] addr_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  logic [XLEN-1:0]   dis_val_i,
  input  fwd_t              ex_fwd_i,
  input  fwd_t              mem_fwd_i,
  output logic [XLEN-1:0]   operand_o,
  output logic              hazard_o
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = fwd_hit(ex_fwd_i, addr_i);
  assign mem_hit = fwd_hit(mem_fwd_i, addr_i);

`ifdef DISPATCH_MEM_FWD_EN
  // MEM bus type is shared with EX; its load flag carries no meaning here.
  logic unused_mem_bits;
  assign unused_mem_bits = mem_fwd_i.is_load;
`else
  // Without MEM forwarding the MEM data path is not consumed at all.
  logic unused_mem_bits;
  assign unused_mem_bits = ^{mem_fwd_i.is_load, mem_fwd_i.data};
`endif

  // Priority select: disabled port, r0, EX ALU result, EX load (stall), MEM, regfile.
  always_comb begin
    operand_o = rf_data_i;
    hazard_o  = 1'b0;
    if (!en_i) begin
      operand_o = dis_val_i;
    end else if (addr_i == '0) begin
      operand_o = '0;
    end else if (ex_hit && !ex_fwd_i.is_load) begin
      operand_o = ex_fwd_i.data;
    end else if (ex_hit) begin
      // Load data is not available until after MEM; the op must wait.
      hazard_o = 1'b1;
    end else if (mem_hit) begin
`ifdef DISPATCH_MEM_FWD_EN
      operand_o = mem_fwd_i.data;
`else
      hazard_o  = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/dispatch_stage.sv
// Dispatch: reads regfile, resolves operands with forwarding, stalls on load-use.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: single output register; in_ready drops on full-and-stalled, hazard, flush or reset.
// DISPATCH_MEM_FWD_EN selects MEM-stage forwarding (undefined: MEM hits stall instead).
module dispatch_stage
  import pipeline_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  dispatch_in_t      in_inst,
  output logic              reg1_read_en,
  output logic              reg2_read_en,
  output logic [REG_AW-1:0] reg1_read_addr,
  output logic [REG_AW-1:0] reg2_read_addr,
  input  logic [XLEN-1:0]   reg1_read_data,
  input  logic [XLEN-1:0]   reg2_read_data,
  input  fwd_t              ex_fwd,
  input  fwd_t              mem_fwd,
  output logic              out_valid,
  input  logic              out_ready,
  output dispatch_out_t     out_inst,
  output logic [31:0]       stall_count
);

  logic          out_valid_q, out_valid_d;
  dispatch_out_t out_inst_q,  out_inst_d;
  logic [31:0]   stall_q,     stall_d;

  logic [XLEN-1:0] operand1, operand2;
  logic            haz1, haz2;
  logic            hazard;
  logic            xfer;

  // Regfile read ports follow the incoming op directly.
  assign reg1_read_en   = in_inst.reg1_en;
  assign reg1_read_addr = in_inst.reg1_addr;
  assign reg2_read_en   = in_inst.reg2_en;
  assign reg2_read_addr = in_inst.reg2_addr;

  // Port 1 falls back to zero when unused.
  operand_mux u_op1 (
    .en_i      (in_inst.reg1_en),
    .addr_i    (in_inst.reg1_addr),
    .rf_data_i (reg1_read_data),
    .dis_val_i ('0),
    .ex_fwd_i  (ex_fwd),
    .mem_fwd_i (mem_fwd),
    .operand_o (operand1),
    .hazard_o  (haz1)
  );

  // Port 2 falls back to the immediate when unused.
  operand_mux u_op2 (
    .en_i      (in_inst.reg2_en),
    .addr_i    (in_inst.reg2_addr),
    .rf_data_i (reg2_read_data),
    .dis_val_i (in_inst.imm),
    .ex_fwd_i  (ex_fwd),
    .mem_fwd_i (mem_fwd),
    .operand_o (operand2),
    .hazard_o  (haz2)
  );

  // A hazard only exists when there is actually an op waiting to go.
  assign hazard   = in_valid && (haz1 || haz2);
  assign in_ready = rst && (!out_valid_q || out_ready) && !hazard && !flush;
  assign xfer     = in_valid && in_ready;

  // Next-state for the output register, valid flag and stall counter.
  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    stall_d     = stall_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (xfer) begin
      out_valid_d          = 1'b1;
      out_inst_d.pc        = in_inst.pc;
      out_inst_d.aluop     = in_inst.aluop;
      out_inst_d.dest_en   = in_inst.dest_en;
      out_inst_d.dest_addr = in_inst.dest_addr;
      out_inst_d.is_load   = in_inst.is_load;
      out_inst_d.operand1  = operand1;
      out_inst_d.operand2  = operand2;
    end else if (out_ready) begin
      // Consumer took the op and nothing replaces it: emit a bubble.
      out_valid_d = 1'b0;
    end

    if (hazard && !flush && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // State registers with synchronous active-low reset; reset drops any held op.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      stall_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      stall_q     <= stall_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_inst    = out_inst_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed bench for dispatch_stage with an expected-output queue and a separate monitor.
// Latency: checks 1-cycle transfer to out_valid.
// Backpressure: exercises hold, bubble, flush and reset-discard paths.
module tb_dispatch_stage;
  import pipeline_types::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  dispatch_in_t  in_inst;
  logic          reg1_read_en, reg2_read_en;
  logic [4:0]    reg1_read_addr, reg2_read_addr;
  logic [31:0]   reg1_read_data, reg2_read_data;
  fwd_t          ex_fwd, mem_fwd;
  logic          out_valid;
  logic          out_ready;
  dispatch_out_t out_inst;
  logic [31:0]   stall_count;

  logic [31:0]   rf [32];

  int checks   = 0;
  int failures = 0;
  dispatch_out_t exp_q[$];
  dispatch_out_t mon_exp;
  dispatch_out_t exp_a;

  always #5 clk = ~clk;

  dispatch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_inst        (in_inst),
    .reg1_read_en   (reg1_read_en),
    .reg2_read_en   (reg2_read_en),
    .reg1_read_addr (reg1_read_addr),
    .reg2_read_addr (reg2_read_addr),
    .reg1_read_data (reg1_read_data),
    .reg2_read_data (reg2_read_data),
    .ex_fwd         (ex_fwd),
    .mem_fwd        (mem_fwd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .stall_count    (stall_count)
  );

  // Regfile model: combinational read.
  always_comb begin
    reg1_read_data = rf[reg1_read_addr];
    reg2_read_data = rf[reg2_read_addr];
  end

  function automatic dispatch_in_t mk_in(input logic [31:0] pc, input logic [3:0] op,
      input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
      input logic de, input logic [4:0] da, input logic ld, input logic [31:0] imm);
    dispatch_in_t r;
    r.pc = pc; r.aluop = op; r.reg1_en = e1; r.reg1_addr = a1;
    r.reg2_en = e2; r.reg2_addr = a2; r.dest_en = de; r.dest_addr = da;
    r.is_load = ld; r.imm = imm;
    return r;
  endfunction

  function automatic dispatch_out_t mk_out(input logic [31:0] pc, input logic [3:0] op,
      input logic de, input logic [4:0] da, input logic ld,
      input logic [31:0] o1, input logic [31:0] o2);
    dispatch_out_t r;
    r.pc = pc; r.aluop = op; r.dest_en = de; r.dest_addr = da; r.is_load = ld;
    r.operand1 = o1; r.operand2 = o2;
    return r;
  endfunction

  function automatic fwd_t mk_fwd(input logic v, input logic ld, input logic [4:0] a,
      input logic [31:0] d);
    fwd_t f;
    f.valid = v; f.is_load = ld; f.addr = a; f.data = d;
    return f;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected: got %0h expected nothing", out_inst);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_inst !== mon_exp) begin
          failures++;
          $display("FAIL out_inst: got %0h expected %0h", out_inst, mon_exp);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[3] = 32'h11;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0;
    ex_fwd = '0; mem_fwd = '0; out_ready = 1'b1;

    // Reset state
    #1 chk("rst_in_ready", in_ready, 0);
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_stall", stall_count, 0);
    rst = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1);

    // Regfile operand, immediate on port 2, 1-cycle latency
    in_inst = mk_in(32'h1000, 4'h1, 1, 5'd3, 0, 5'd0, 1, 5'd10, 0, 32'h1234);
    in_valid = 1'b1;
    #1 chk("req024_in_ready", in_ready, 1);
    chk("rd1_en", reg1_read_en, 1);
    chk("rd1_addr", reg1_read_addr, 3);
    chk("rd2_en", reg2_read_en, 0);
    exp_q.push_back(mk_out(32'h1000, 4'h1, 1, 5'd10, 0, 32'h11, 32'h1234));
    step();
    chk("req024_latency", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("drain_bubble", out_valid, 0);

    // EX beats MEM on the same register; back-to-back transfers follow
    in_inst = mk_in(32'h2000, 4'h2, 1, 5'd3, 1, 5'd6, 1, 5'd11, 0, 32'h0);
    ex_fwd  = mk_fwd(1, 0, 5'd3, 32'hAA);
    mem_fwd = mk_fwd(1, 0, 5'd3, 32'hBB);
    in_valid = 1'b1;
    exp_q.push_back(mk_out(32'h2000, 4'h2, 1, 5'd11, 0, 32'hAA, 32'h106));
    step();

    // r0 always reads zero, even with a matching forward
    in_inst = mk_in(32'h3000, 4'h3, 1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 32'h77);
    ex_fwd  = mk_fwd(1, 0, 5'd0, 32'hFF);
    mem_fwd = '0;
    #1 chk("req027_no_hazard", in_ready, 1);
    exp_q.push_back(mk_out(32'h3000, 4'h3, 0, 5'd0, 1, 32'h0, 32'h0));
    step();

    // Port 2 EX forward over MEM; disabled port 1 yields zero
    in_inst = mk_in(32'h4000, 4'h4, 0, 5'd9, 1, 5'd5, 1, 5'd12, 0, 32'h99);
    ex_fwd  = mk_fwd(1, 0, 5'd5, 32'hCAFE);
    mem_fwd = mk_fwd(1, 0, 5'd5, 32'hBEEF);
    exp_q.push_back(mk_out(32'h4000, 4'h4, 1, 5'd12, 0, 32'h0, 32'hCAFE));
    step();
    in_valid = 1'b0; ex_fwd = '0; mem_fwd = '0;
    step();
    chk("drain2", out_valid, 0);

    // Load match without a valid op is not a stall
    in_inst = mk_in(32'h5000, 4'h5, 0, 5'd0, 1, 5'd5, 1, 5'd13, 0, 32'h0);
    ex_fwd  = mk_fwd(1, 1, 5'd5, 32'hDEAD);
    step();
    chk("no_stall_idle", stall_count, 0);

    // Load-use on port 2 for two cycles
    in_valid = 1'b1;
    #1 chk("req026_ready_c1", in_ready, 0);
    step();
    chk("req026_bubble_c1", out_valid, 0);
    chk("req026_ready_c2", in_ready, 0);
    step();
    chk("req026_bubble_c2", out_valid, 0);
    chk("req026_stall_count", stall_count, 2);
    ex_fwd = '0;
    #1 chk("req026_release", in_ready, 1);
    exp_q.push_back(mk_out(32'h5000, 4'h5, 1, 5'd13, 0, 32'h0, 32'h105));
    step();
    chk("req026_out_valid", out_valid, 1);

    // Flush masks the stall counter and blocks input
    ex_fwd = mk_fwd(1, 1, 5'd5, 32'h0);
    flush = 1'b1;
    #1 chk("flush_in_ready", in_ready, 0);
    step();
    chk("flush_no_stall", stall_count, 2);
    chk("flush_out_valid", out_valid, 0);
    flush = 1'b0; ex_fwd = '0; in_valid = 1'b0;

    // Held output under backpressure, then flushed
    out_ready = 1'b0;
    in_inst = mk_in(32'h6000, 4'h6, 1, 5'd1, 0, 5'd0, 1, 5'd14, 0, 32'h66);
    exp_a = mk_out(32'h6000, 4'h6, 1, 5'd14, 0, 32'h101, 32'h66);
    in_valid = 1'b1;
    step();
    chk("req028_valid", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      in_inst = mk_in(32'h7000 + i, 4'h7, 1, 5'd2, 1, 5'd4, 1, 5'd1, 0, 32'h0);
      rf[1] = 32'hF00 + i;
      #1 chk("req028_in_ready", in_ready, 0);
      step();
      chk("req028_hold", out_inst, exp_a);
    end
    rf[1] = 32'h101;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("req028_flush", out_valid, 0);

    // Held op released in the same cycle a new op enters
    in_inst = mk_in(32'hB000, 4'hB, 1, 5'd4, 0, 5'd0, 1, 5'd2, 0, 32'h1);
    exp_q.push_back(mk_out(32'hB000, 4'hB, 1, 5'd2, 0, 32'h104, 32'h1));
    step();
    in_inst = mk_in(32'hC000, 4'hC, 0, 5'd0, 1, 5'd8, 0, 5'd0, 0, 32'h2);
    #1 chk("held_in_ready", in_ready, 0);
    step();
    chk("held_valid", out_valid, 1);
    out_ready = 1'b1;
    #1 chk("release_in_ready", in_ready, 1);
    exp_q.push_back(mk_out(32'hC000, 4'hC, 0, 5'd0, 0, 32'h0, 32'h108));
    step();
    in_valid = 1'b0;
    step();

    // MEM forwarding build option
    in_inst = mk_in(32'h8000, 4'h8, 1, 5'd7, 0, 5'd0, 1, 5'd15, 0, 32'h0);
    mem_fwd = mk_fwd(1, 0, 5'd7, 32'h55);
    in_valid = 1'b1;
`ifdef DISPATCH_MEM_FWD_EN
    #1 chk("memfwd_in_ready", in_ready, 1);
    exp_q.push_back(mk_out(32'h8000, 4'h8, 1, 5'd15, 0, 32'h55, 32'h0));
    step();
    chk("memfwd_stall", stall_count, 2);
`else
    #1 chk("req029_in_ready", in_ready, 0);
    step();
    chk("req029_stall", stall_count, 3);
    chk("req029_bubble", out_valid, 0);
    mem_fwd = '0;
    exp_q.push_back(mk_out(32'h8000, 4'h8, 1, 5'd15, 0, 32'h107, 32'h0));
    step();
`endif
    mem_fwd = '0;
    in_valid = 1'b0;
    step();

    // Reset while an op is held: it must vanish
    out_ready = 1'b0;
    in_inst = mk_in(32'h9000, 4'h9, 1, 5'd2, 0, 5'd0, 1, 5'd3, 0, 32'h9);
    in_valid = 1'b1;
    step();
    chk("pre_rst_held", out_valid, 1);
    in_valid = 1'b0;
    rst = 1'b0;
    #1 chk("mid_rst_in_ready", in_ready, 0);
    step();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_inst", out_inst, 0);
    chk("mid_rst_stall", stall_count, 0);
    rst = 1'b1;
    out_ready = 1'b1;
    step(); step();
    chk("post_rst_no_emit", out_valid, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dispatch_stage.md
DISPATCH_STAGE -- requirements
Module: dispatch_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-low.
REQ-002 SHALL have: flush  in  1  kill in-flight op (branch/exception).
REQ-003 SHALL have: in_valid  in  1; in_ready  out  1; in_inst  in  dispatch_in_t  decoded op (pc, aluop, reg1_en/addr, reg2_en/addr, dest_en/addr, is_load, imm).
REQ-004 SHALL have: reg1_read_en, reg2_read_en  out  1 each; reg1_read_addr, reg2_read_addr  out  5 each; reg1_read_data, reg2_read_data  in  32 each (regfile read ports).
REQ-005 SHALL have: ex_fwd  in  fwd_t  {valid, is_load, addr[5], data[32]}; mem_fwd  in  fwd_t  {valid, addr[5], data[32]}.
REQ-006 SHALL have: out_valid  out  1; out_ready  in  1; out_inst  out  dispatch_out_t  (pc, aluop, dest_en/addr, is_load, operand1[32], operand2[32]).
REQ-007 SHALL have: stall_count  out  32  load-use stall cycle counter.

Function
REQ-008 Read ports SHALL be driven combinationally from in_inst: readN_en = regN_en, readN_addr = regN_addr.
REQ-009 Operand source per port SHALL be, in priority: addr==0 -> 0; ex_fwd match (valid, !is_load, addr equal) -> ex_fwd.data; mem_fwd match -> mem_fwd.data; else regN_read_data; regN_en=0 -> operand = imm for port 2, 0 for port 1.
REQ-010 Load-use hazard SHALL be asserted when in_valid and ex_fwd.valid and ex_fwd.is_load and ex_fwd.addr!=0 and ex_fwd.addr equals an enabled source address.
REQ-011 in_ready SHALL equal (!out_valid || out_ready) && !hazard && !flush.
REQ-012 Input transfer (in_valid && in_ready) SHALL register out_inst with resolved operands and set out_valid next cycle; latency exactly 1 cycle.
REQ-013 When out_ready && out_valid and no transfer occurs, out_valid SHALL clear next cycle (bubble inserted during hazard).
REQ-014 When out_valid && !out_ready, out_inst and out_valid SHALL hold unchanged; operands SHALL NOT be re-resolved.
REQ-015 flush SHALL clear out_valid next cycle regardless of out_ready or in_valid; no input transfer in the flush cycle.
REQ-016 stall_count SHALL increment by 1 each cycle hazard is asserted and flush is low, saturating at 0xFFFF_FFFF.
REQ-017 Simultaneous ex_fwd and mem_fwd matches on the same address SHALL select ex_fwd.

Reset
REQ-018 With rst==0 at a clk edge: out_valid=0, out_inst=0, stall_count=0; in_ready SHALL be 0 while rst==0.
REQ-019 Reset mid-transfer SHALL discard the held op without emitting it.

Configuration
REQ-020 Macro DISPATCH_MEM_FWD_EN defined: mem_fwd forwarding per REQ-009.
REQ-021 Macro DISPATCH_MEM_FWD_EN undefined: mem_fwd match SHALL instead count as a hazard (stall, REQ-010/011/016 apply); mem_fwd data SHALL be unused.

Structure
REQ-022 dispatch_in_t, dispatch_out_t, fwd_t SHALL live in package pipeline_types.
REQ-023 Operand selection SHALL be one sub-module operand_mux, instantiated twice (port 1, port 2).

Verification
REQ-024 reg1=r3, regfile r3=0x11, no fwd -> operand1=0x11, out_valid one cycle after transfer.
REQ-025 reg1=r3, ex_fwd{1,0,r3,0xAA}, mem_fwd{1,r3,0xBB} -> operand1=0xAA.
REQ-026 reg2=r5, ex_fwd{1,1,r5,x} for 2 cycles -> in_ready=0 both cycles, out_valid=0 (bubble), stall_count=2.
REQ-027 reg1=r0, ex_fwd{1,0,r0,0xFF} -> operand1=0, no hazard.
REQ-028 out_valid=1, out_ready=0 for 3 cycles with changing in_inst -> out_inst stable, in_ready=0; then flush -> out_valid=0 next cycle.
REQ-029 Without DISPATCH_MEM_FWD_EN, mem_fwd{1,r7,0x55}, reg1=r7 -> in_ready=0, stall_count increments.
